// File: rtl/f_pkg.sv
// rtl/f_pkg.sv - shared width constant and FSM state type for the squared-sum block
package f_pkg;

  localparam int F_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    MUL  = 2'd2
  } f_state_t;

endpackage

// File: rtl/f_seq_mul.sv
// rtl/f_seq_mul.sv - shift-add squarer datapath: one multiplier bit per cycle, LSB first
module f_seq_mul
  import f_pkg::*;
#(
  parameter int WIDTH = F_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             finish,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic [CW-1:0]    cnt;

  // The wrapped sum feeds both multiplicand and multiplier, so the result is a square.
  assign sum     = opa + opb;
  assign addend  = mplier[0] ? mcand : '0;
  // product is the accumulator including the current iteration's partial product,
  // so the final value is available on the same edge as the last step.
  assign product = acc + addend;
  assign finish  = busy && (cnt == CW'(WIDTH - 1));

  // Load operands on request, then step one multiplier bit per cycle until the last bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (load) begin
      mcand  <= sum;
      mplier <= sum;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (finish) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/blk_7b0fd9.sv
// rtl/blk_7b0fd9.sv - registered (a+b)^2 mod 2^WIDTH with fixed WIDTH+1 cycle latency
module blk_7b0fd9
  import f_pkg::*;
#(
  parameter int WIDTH = F_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  f_state_t         state;
  f_state_t         state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             accept;
  logic             load;
  logic             complete;
  logic             mul_busy;
  logic             mul_finish;
  logic [WIDTH-1:0] mul_product;

  f_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .opa     (opa),
    .opb     (opb),
    .busy    (mul_busy),
    .finish  (mul_finish),
    .product (mul_product)
  );

  // State register; reset wins over any start on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control strobes; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SUM;
        end
      end
      SUM: begin
        load      = 1'b1;
        state_nxt = MUL;
      end
      MUL: begin
        if (mul_busy && mul_finish) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture and output registers; result only changes when a new square lands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      opa    <= '0;
      opb    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      if (accept) begin
        opa  <= a;
        opb  <= b;
        done <= 1'b0;
      end
      if (complete) begin
        result <= mul_product;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_blk_7b0fd9.sv
// tb/tb_blk_7b0fd9.sv - self-checking bench for blk_7b0fd9 against an arithmetic model
module tb_blk_7b0fd9;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         done;

  int           total;
  int           bad;
  logic [W-1:0] prev_res;

  blk_7b0fd9 #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0]   s;
    logic [2*W-1:0] sq;
    s  = x + y;
    sq = {{W{1'b0}}, s} * {{W{1'b0}}, s};
    return sq[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: plain; mode 1: extra start pulse mid-MUL; mode 2: operands scrambled every cycle
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int mode);
    int n;
    logic [W-1:0] expv;
    expv  = model(ta, tb_);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    @(posedge clk);
    @(negedge clk);
    chk("done_clear", {31'd0, done}, 32'd0);
    chk("result_keep", result, prev_res);
    start = 1'b0;
    n = 0;
    while (n < 100) begin
      if (mode == 1 && n == 10) begin
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
      end else if (mode == 1 && n == 11) begin
        start = 1'b0;
      end
      if (mode == 2) begin
        a = $urandom;
        b = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
      if (done) break;
    end
    start = 1'b0;
    chk("latency", n, LAT);
    chk("result", result, expv);
    prev_res = expv;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    prev_res = '0;
    reset    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    do_op(32'd1, 32'd2, 0);
    do_op(32'd7, 32'd4, 0);
    do_op(32'd0, 32'd0, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 0);
    do_op(32'h0001_0000, 32'd0, 0);
    do_op(32'h0000_FFFF, 32'd0, 0);

    // result and done hold while idle
    repeat (5) @(negedge clk);
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_result", result, prev_res);

    do_op(32'd3, 32'd4, 1);

    // reset mid-MUL aborts the operation
    start = 1'b1;
    a     = 32'd5;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    begin
      int rises;
      rises = 0;
      repeat (50) begin
        @(negedge clk);
        if (done) rises++;
      end
      chk("abort_quiet", rises, 0);
    end
    prev_res = '0;
    do_op(32'd2, 32'd3, 0);

    do_op(32'd10, 32'd6, 2);

    for (int i = 0; i < 8; i++) begin
      do_op($urandom, $urandom, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blk_7b0fd9.md
F -- requirements
Module: f

Interface
REQ-001 SHALL have parameter WIDTH, default 32, setting the operand and result bit width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled on the rising edge of clk.
REQ-005 SHALL have port a, input, WIDTH bits: first operand, unsigned.
REQ-006 SHALL have port b, input, WIDTH bits: second operand, unsigned.
REQ-007 SHALL have port result, output, WIDTH bits: registered (a+b)*(a+b) mod 2^WIDTH.
REQ-008 SHALL have port done, output, 1 bit: registered flag meaning result is valid.

Function
REQ-009 SHALL compute result = ((a+b) mod 2^WIDTH)^2 mod 2^WIDTH; sum and product both wrap, unsigned.
REQ-010 SHALL implement FSM states IDLE, SUM and MUL.
REQ-011 In IDLE, on a rising edge with start=1, SHALL latch a and b, clear done, and move to SUM.
REQ-012 SUM SHALL take exactly one cycle: register s = a+b as both multiplicand and multiplier, clear the accumulator and iteration counter, then move to MUL.
REQ-013 MUL SHALL use a sequential shift-add multiplier processing one multiplier bit per cycle, LSB first, for exactly WIDTH cycles.
REQ-014 After the final MUL iteration, SHALL load result with the accumulator, set done=1, and return to IDLE in the same edge.
REQ-015 Latency SHALL be fixed at WIDTH+1 edges after the start-accepting edge (33 for WIDTH=32), independent of operand values.
REQ-016 done and result SHALL hold their values in IDLE until the next start is accepted.
REQ-017 Accepting a new start SHALL clear done; result SHALL keep its old value until the new result is loaded.
REQ-018 start SHALL be ignored while in SUM or MUL; the in-flight operation SHALL complete unaffected.
REQ-019 Changes on a and b after the accepting edge SHALL NOT affect the in-flight result.
REQ-020 start held high in IDLE with done=1 SHALL begin a new operation on each such edge.

Reset
REQ-021 When reset=0 at a rising edge, SHALL set state=IDLE, done=0, result=0, and clear the accumulator, counter and operand registers.
REQ-022 Reset mid-operation SHALL abort the operation; no done pulse SHALL follow until a new start is accepted.
REQ-023 Reset SHALL take priority over start on the same edge.

Structure
REQ-024 A shared package f_pkg SHALL hold the default WIDTH constant and the state enumeration typedef (IDLE, SUM, MUL).
REQ-025 The datapath SHALL be one sub-module, f_seq_mul, containing the accumulator, shift registers and counter, with load/busy/finish handshake to the top-level FSM.

Verification
REQ-026 Reset, then start with a=1, b=2 -> done rises 33 cycles later; result=9.
REQ-027 After REQ-026, start with a=7, b=4 -> done falls the next cycle, rises 33 cycles later; result=121.
REQ-028 a=0, b=0 -> result=0; a=0xFFFFFFFF, b=1 -> result=0 (sum wrap); a=0x00010000, b=0 -> result=0 (product wrap); a=0xFFFF, b=0 -> result=0xFFFE0001.
REQ-029 Start with a=3, b=4, then pulse start with a=9, b=9 during MUL -> result=49; second start ignored.
REQ-030 Start with a=5, b=5, assert reset=0 for one cycle mid-MUL -> done=0 and result=0, stays so with start=0; a fresh start with a=2, b=3 -> result=25.
REQ-031 Change a and b every cycle after start with a=10, b=6 accepted -> result=256.
